// File: rtl/ika2151_timer.sv
// ika2151_timer
// Timer A / Timer B stage. Both timers count sample-period ticks (i_CYCLE_31)
// on the phi1 negative-edge clock enable, reload from their value registers on
// overflow, and raise flags that combine into the active-low chip IRQ. Timer A
// also emits a one-enable overflow pulse used as the CSM key-on trigger.
module ika2151_timer #(
  parameter int TA_WIDTH    = 10,
  parameter int TB_WIDTH    = 8,
  parameter int TB_PRESCALE = 16
) (
  input  logic                i_EMUCLK,
  input  logic                i_RST,
  input  logic                i_phi1_NCEN_n,
  input  logic                i_CYCLE_31,
  input  logic [TA_WIDTH-1:0] i_TA_VAL,
  input  logic [TB_WIDTH-1:0] i_TB_VAL,
  input  logic                i_LOAD_A,
  input  logic                i_LOAD_B,
  input  logic                i_IRQEN_A,
  input  logic                i_IRQEN_B,
  input  logic                i_FRST_A,
  input  logic                i_FRST_B,
  output logic                o_TA_FLAG,
  output logic                o_TB_FLAG,
  output logic                o_TA_OVFL,
  output logic                o_IRQ_n
);

  // Prescaler width; a prescale of 1 still gets a 1-bit register that
  // simply wraps on every tick.
  localparam int TB_PRE_W = (TB_PRESCALE > 1) ? $clog2(TB_PRESCALE) : 1;

  localparam logic [TA_WIDTH-1:0] TA_ONE  = TA_WIDTH'(1);
  localparam logic [TB_WIDTH-1:0] TB_ONE  = TB_WIDTH'(1);
  localparam logic [TB_PRE_W-1:0] PRE_ONE = TB_PRE_W'(1);
  localparam logic [TB_PRE_W-1:0] PRE_TOP = TB_PRE_W'(TB_PRESCALE - 1);

  // State registers and their next-state values.
  logic                ta_ld_z_q, ta_ld_z_d;
  logic                tb_ld_z_q, tb_ld_z_d;
  logic [TA_WIDTH-1:0] ta_cnt_q,  ta_cnt_d;
  logic [TB_WIDTH-1:0] tb_cnt_q,  tb_cnt_d;
  logic [TB_PRE_W-1:0] tb_pre_q,  tb_pre_d;
  logic                ta_flag_q, ta_flag_d;
  logic                tb_flag_q, tb_flag_d;
  logic                ta_ovfl_q, ta_ovfl_d;
  logic                irq_n_q,   irq_n_d;

  // Decoded per-enable events.
  logic ce;
  logic ta_load_edge, ta_run, ta_tick, ta_ovf;
  logic tb_load_edge, tb_run, tb_pre_wrap, tb_tick, tb_ovf;

  assign ce = ~i_phi1_NCEN_n;

  // A timer is "running" once the load bit has been high for at least one
  // enable; the first enable with the bit high is the load edge, which
  // reloads the counter and never counts, even if a tick is present.
  assign ta_load_edge = i_LOAD_A & ~ta_ld_z_q;
  assign ta_run       = i_LOAD_A &  ta_ld_z_q;
  assign ta_tick      = ta_run & i_CYCLE_31;

  assign tb_load_edge = i_LOAD_B & ~tb_ld_z_q;
  assign tb_run       = i_LOAD_B &  tb_ld_z_q;
  assign tb_pre_wrap  = (tb_pre_q == PRE_TOP);
  assign tb_tick      = tb_run & i_CYCLE_31 & tb_pre_wrap;

  // Timer A next state: load edge reloads, tick counts, all-ones tick
  // reloads from the current value register and signals overflow.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ta_cnt_d  = ta_cnt_q;
    ta_ovf    = 1'b0;
    ta_ld_z_d = i_LOAD_A;
    if (ta_load_edge) begin
      ta_cnt_d = i_TA_VAL;
    end else if (ta_tick) begin
      if (&ta_cnt_q) begin
        ta_cnt_d = i_TA_VAL;
        ta_ovf   = 1'b1;
      end else begin
        ta_cnt_d = ta_cnt_q + TA_ONE;
      end
    end
  end

  // Timer B next state: the prescaler advances on every running sample
  // tick and the counter advances only when the prescaler wraps.
  always_comb begin
    tb_cnt_d  = tb_cnt_q;
    tb_pre_d  = tb_pre_q;
    tb_ovf    = 1'b0;
    tb_ld_z_d = i_LOAD_B;
    if (tb_load_edge) begin
      tb_cnt_d = i_TB_VAL;
      tb_pre_d = '0;
    end else if (tb_run && i_CYCLE_31) begin
      tb_pre_d = tb_pre_wrap ? '0 : (tb_pre_q + PRE_ONE);
      if (tb_tick) begin
        if (&tb_cnt_q) begin
          tb_cnt_d = i_TB_VAL;
          tb_ovf   = 1'b1;
        end else begin
          tb_cnt_d = tb_cnt_q + TB_ONE;
        end
      end
    end
  end

  // Flags: an enabled overflow sets, a clear strobe clears, and a set in the
  // same enable as a clear wins. Disabling the IRQ does not clear a flag.
  // IRQ is derived from the next-state flags so it moves on the same edge.
  always_comb begin
    ta_flag_d = ta_flag_q;
    tb_flag_d = tb_flag_q;
    if (ta_ovf && i_IRQEN_A) begin
      ta_flag_d = 1'b1;
    end else if (i_FRST_A) begin
      ta_flag_d = 1'b0;
    end
    if (tb_ovf && i_IRQEN_B) begin
      tb_flag_d = 1'b1;
    end else if (i_FRST_B) begin
      tb_flag_d = 1'b0;
    end
    ta_ovfl_d = ta_ovf;
    irq_n_d   = ~(ta_flag_d | tb_flag_d);
  end

  // State update on the phi1 clock enable, asynchronous reset.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      ta_ld_z_q <= 1'b0;
      tb_ld_z_q <= 1'b0;
      ta_cnt_q  <= '0;
      tb_cnt_q  <= '0;
      tb_pre_q  <= '0;
      ta_flag_q <= 1'b0;
      tb_flag_q <= 1'b0;
      ta_ovfl_q <= 1'b0;
      irq_n_q   <= 1'b1;
    end else if (ce) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others, matching the hardware.
      ta_ld_z_q <= ta_ld_z_d;
      tb_ld_z_q <= tb_ld_z_d;
      ta_cnt_q  <= ta_cnt_d;
      tb_cnt_q  <= tb_cnt_d;
      tb_pre_q  <= tb_pre_d;
      ta_flag_q <= ta_flag_d;
      tb_flag_q <= tb_flag_d;
      ta_ovfl_q <= ta_ovfl_d;
      irq_n_q   <= irq_n_d;
    end
  end

  assign o_TA_FLAG = ta_flag_q;
  assign o_TB_FLAG = tb_flag_q;
  assign o_TA_OVFL = ta_ovfl_q;
  assign o_IRQ_n   = irq_n_q;

endmodule

// File: tb/tb_ika2151_timer.sv
// Directed bench for ika2151_timer. One phi1 enable is every second EMUCLK
// cycle. Status is compared as {o_TA_OVFL, o_TA_FLAG, o_TB_FLAG, o_IRQ_n}.
module tb_ika2151_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ncen;
  logic       c31;
  logic [9:0] ta_val;
  logic [7:0] tb_val;
  logic       load_a, load_b, irqen_a, irqen_b, frst_a, frst_b;
  logic       ta_flag, tb_flag, ta_ovfl, irq_n;
  logic [3:0] status;

  int n_cmp = 0;
  int n_bad = 0;

  assign status = {ta_ovfl, ta_flag, tb_flag, irq_n};

  ika2151_timer #(
    .TA_WIDTH   (10),
    .TB_WIDTH   (8),
    .TB_PRESCALE(16)
  ) dut (
    .i_EMUCLK     (clk),
    .i_RST        (rst),
    .i_phi1_NCEN_n(ncen),
    .i_CYCLE_31   (c31),
    .i_TA_VAL     (ta_val),
    .i_TB_VAL     (tb_val),
    .i_LOAD_A     (load_a),
    .i_LOAD_B     (load_b),
    .i_IRQEN_A    (irqen_a),
    .i_IRQEN_B    (irqen_b),
    .i_FRST_A     (frst_a),
    .i_FRST_B     (frst_b),
    .o_TA_FLAG    (ta_flag),
    .o_TB_FLAG    (tb_flag),
    .o_TA_OVFL    (ta_ovfl),
    .o_IRQ_n      (irq_n)
  );

  always #5 clk = ~clk;

  // One enabled edge followed by one disabled edge; returns 1 time unit
  // after the disabled edge, where outputs are stable.
  task automatic en_cycle();
    @(negedge clk); ncen = 1'b0;
    @(posedge clk);
    @(negedge clk); ncen = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic tick_en(input logic t);
    c31 = t;
    en_cycle();
    c31 = 1'b0;
  endtask

  // One sample period: 31 plain enables then the CYCLE_31 enable.
  task automatic period();
    repeat (31) en_cycle();
    tick_en(1'b1);
  endtask

  task automatic burst(input int n);
    repeat (n) tick_en(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; ncen = 1'b1; c31 = 1'b0;
    ta_val = '0; tb_val = '0;
    load_a = 0; load_b = 0; irqen_a = 0; irqen_b = 0; frst_a = 0; frst_b = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    en_cycle();
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", status, 4'b0001);
    end
  endtask

  task automatic test_timer_a();
    ta_val = 10'h3FE; irqen_a = 1'b1; load_a = 1'b1;
    en_cycle();                 // load edge: cnt = 3FE
    period();                   // cnt = 3FF
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL a_first_tick: got %b want %b", status, 4'b0001);
    end
    period();                   // overflow
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL a_overflow: got %b want %b", status, 4'b1100);
    end
    en_cycle();
    n_cmp++;
    if (status !== 4'b0100) begin
      n_bad++; $display("FAIL a_ovfl_one_cycle: got %b want %b", status, 4'b0100);
    end
    frst_a = 1'b1; en_cycle(); frst_a = 1'b0;
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL a_frst_clear: got %b want %b", status, 4'b0001);
    end
    repeat (29) en_cycle();
    tick_en(1'b1);              // 32 enables after overflow: cnt = 3FF
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL a_mid_period: got %b want %b", status, 4'b0001);
    end
    period();                   // 64 enables after the first overflow
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL a_repeat_overflow: got %b want %b", status, 4'b1100);
    end
    load_a = 1'b0; frst_a = 1'b1; en_cycle(); frst_a = 1'b0;
  endtask

  task automatic test_timer_b();
    irqen_a = 1'b0;
    tb_val = 8'hFF; irqen_b = 1'b1; load_b = 1'b1;
    en_cycle();                 // load edge: cnt = FF, prescaler = 0
    repeat (15) period();
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL b_before_16: got %b want %b", status, 4'b0001);
    end
    period();
    n_cmp++;
    if (status !== 4'b0010) begin
      n_bad++; $display("FAIL b_overflow_16: got %b want %b", status, 4'b0010);
    end
    en_cycle();
    n_cmp++;
    if (status !== 4'b0010) begin
      n_bad++; $display("FAIL b_flag_holds: got %b want %b", status, 4'b0010);
    end
    frst_b = 1'b1; en_cycle(); frst_b = 1'b0;
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL b_frst_clear: got %b want %b", status, 4'b0001);
    end
    repeat (15) period();
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL b_second_before: got %b want %b", status, 4'b0001);
    end
    period();
    n_cmp++;
    if (status !== 4'b0010) begin
      n_bad++; $display("FAIL b_second_overflow: got %b want %b", status, 4'b0010);
    end
    load_b = 1'b0; frst_b = 1'b1; en_cycle(); frst_b = 1'b0;
  endtask

  task automatic test_no_irq();
    irqen_a = 1'b0; ta_val = 10'h3FF; load_a = 1'b1;
    en_cycle();                 // load edge: cnt = 3FF
    for (int i = 0; i < 3; i++) begin
      period();
      n_cmp++;
      if (status !== 4'b1001) begin
        n_bad++; $display("FAIL noirq_pulse[%0d]: got %b want %b", i, status, 4'b1001);
      end
      en_cycle();
      n_cmp++;
      if (status !== 4'b0001) begin
        n_bad++; $display("FAIL noirq_after[%0d]: got %b want %b", i, status, 4'b0001);
      end
    end
  endtask

  task automatic test_load_hold();
    irqen_a = 1'b1; load_a = 1'b0;
    en_cycle();
    ta_val = 10'h1FE; load_a = 1'b1;
    tick_en(1'b1);              // load edge with tick present: cnt = 1FE, no count
    burst(2);                   // cnt = 200
    load_a = 1'b0;
    burst(10);                  // held
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL hold_no_ovfl: got %b want %b", status, 4'b0001);
    end
    ta_val = 10'h3FC; load_a = 1'b1;
    tick_en(1'b1);              // reload 3FC
    burst(3);                   // 3FD, 3FE, 3FF
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL reload_pre_ovfl: got %b want %b", status, 4'b0001);
    end
    burst(1);
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL reload_ovfl: got %b want %b", status, 4'b1100);
    end
    ta_val = 10'h3FF;           // changed while running: cnt keeps 3FC path
    burst(3);
    n_cmp++;
    if (status !== 4'b0100) begin
      n_bad++; $display("FAIL val_change_no_effect: got %b want %b", status, 4'b0100);
    end
    burst(1);                   // overflow, reload new value 3FF
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL val_change_ovfl: got %b want %b", status, 4'b1100);
    end
    burst(1);
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL val_change_reload: got %b want %b", status, 4'b1100);
    end
  endtask

  task automatic test_enable_gate();
    c31 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    c31 = 1'b0;
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL gate_hold: got %b want %b", status, 4'b1100);
    end
    en_cycle();
    n_cmp++;
    if (status !== 4'b0100) begin
      n_bad++; $display("FAIL gate_release: got %b want %b", status, 4'b0100);
    end
  endtask

  task automatic test_flag_rules();
    irqen_a = 1'b0;
    en_cycle();
    n_cmp++;
    if (status !== 4'b0100) begin
      n_bad++; $display("FAIL irqen_low_keeps: got %b want %b", status, 4'b0100);
    end
    irqen_a = 1'b1; frst_a = 1'b1;
    en_cycle();
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL flag_clear: got %b want %b", status, 4'b0001);
    end
    tick_en(1'b1);              // overflow with FRST_A high: set wins
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL set_wins: got %b want %b", status, 4'b1100);
    end
    en_cycle();
    frst_a = 1'b0;
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL next_frst_clears: got %b want %b", status, 4'b0001);
    end
  endtask

  task automatic test_async_reset();
    tick_en(1'b1);              // cnt was 3FF: overflow
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL pre_reset_ovfl: got %b want %b", status, 4'b1100);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL async_reset: got %b want %b", status, 4'b0001);
    end
    #1 rst = 1'b0;
    tick_en(1'b1);              // load delay was reset: this is a load edge
    n_cmp++;
    if (status !== 4'b0001) begin
      n_bad++; $display("FAIL post_reset_edge: got %b want %b", status, 4'b0001);
    end
    tick_en(1'b1);
    n_cmp++;
    if (status !== 4'b1100) begin
      n_bad++; $display("FAIL post_reset_ovfl: got %b want %b", status, 4'b1100);
    end
  endtask

  initial begin
    test_reset();
    test_timer_a();
    test_timer_b();
    test_no_irq();
    test_load_hold();
    test_enable_gate();
    test_flag_rules();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
